// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used as the serial adder's datapath.
module full_adder (
  input  logic i_x,
  input  logic i_y,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_x ^ i_y ^ i_carry;
  assign o_carry = (i_x & i_y) | (i_carry & (i_x ^ i_y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, LSB first, through a single full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output o_overflow.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic             carry_q;
  logic [CNT_W-1:0] count;
  logic             cell_sum;
  logic             cell_carry;
  logic             last_bit;
  logic             accept;

  full_adder u_cell (
    .i_x     (x_sh[0]),
    .i_y     (y_sh[0]),
    .i_carry (carry_q),
    .o_sum   (cell_sum),
    .o_carry (cell_carry)
  );

  assign last_bit = (count == CNT_W'(WIDTH - 1));
  assign accept   = i_start && (state != RUN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = i_start ? RUN : IDLE;
      RUN:     state_next = last_bit ? DONE : RUN;
      DONE:    state_next = i_start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy/done are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      x_sh       <= '0;
      y_sh       <= '0;
      carry_q    <= 1'b0;
      count      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      o_overflow <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      o_busy <= (state_next == RUN);
      o_done <= (state_next == DONE);
      if (accept) begin
        x_sh       <= i_x;
        y_sh       <= i_y;
        carry_q    <= i_carry;
        count      <= '0;
        o_sum      <= '0;
`ifdef SERIAL_ADDER_OVF_EN
        o_overflow <= 1'b0;
`endif
      end else if (state == RUN) begin
        x_sh    <= x_sh >> 1;
        y_sh    <= y_sh >> 1;
        carry_q <= cell_carry;
        o_sum   <= {cell_sum, o_sum[WIDTH-1:1]};
        count   <= last_bit ? count : count + CNT_W'(1);
        // Result flags are captured only on the MSB cycle; carry_q is then the MSB carry-in.
        if (last_bit) begin
          o_carry    <= cell_carry;
`ifdef SERIAL_ADDER_OVF_EN
          o_overflow <= carry_q ^ cell_carry;
`endif
        end
      end
    end
  end

endmodule
